// File: rtl/led_pkg.sv
// Shared definitions for the LED indicator blocks: display mode encodings
// and the pin level of an unlit LED for a given polarity.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_MARQUEE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_e;

    // Pin level that leaves an LED dark; a lit LED drives the inverse.
    function automatic logic LED_OFF(input int activeLow);
        return (activeLow != 0);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks,
// asserted on the cycle the count wraps.
module tick_gen #(
    parameter int TICK_DIV = 27000
) (
    input  logic i_clk,
    input  logic i_sys_rst_n,
    output logic o_tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] r_count;

    assign o_tick = (r_count == CW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/led_indicator_ctrl.sv
// LED bank driver: latched data shown as static, blinking, marquee or off,
// PWM-dimmed, plus a pulse-stretched key-press LED in the top bit.
module led_indicator_ctrl
    import led_pkg::*;
#(
    parameter int DATA_W        = 4,
    parameter int PWM_BITS      = 4,
    parameter int TICK_DIV      = 27000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 50,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                i_clk,
    input  logic                i_sys_rst_n,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_data_valid,
    input  logic                i_is_pressed,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic [DATA_W:0]     o_led
);

    localparam int   BW      = $clog2(BLINK_TICKS + 1);
    localparam int   SW      = $clog2(STRETCH_TICKS + 1);
    localparam int   PW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic OFF_LVL = LED_OFF(ACTIVE_LOW);

    logic                w_tick;
    logic [DATA_W-1:0]   r_data;
    mode_e               r_mode;
    logic [PWM_BITS-1:0] r_bright;
    logic [PWM_BITS-1:0] r_pwm;
    logic [BW-1:0]       r_blinkCnt;
    logic                r_phase;
    logic [PW-1:0]       r_pos;
    logic [SW-1:0]       r_stretch;
    logic                r_pressPrev;

    logic                w_modeChange;
    logic                w_blinkWrap;
    logic                w_pressRise;
    logic [DATA_W-1:0]   w_oneHot;
    logic [DATA_W-1:0]   w_pre;
    logic                w_pwmOn;
    logic [DATA_W-1:0]   w_dataLit;
    logic                w_pressLit;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk       (i_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .o_tick      (w_tick)
    );

    // r_mode doubles as the previous sampled mode for change detection.
    assign w_modeChange = (i_mode != r_mode);
    assign w_blinkWrap  = w_tick && (r_blinkCnt == BW'(BLINK_TICKS - 1));
    assign w_pressRise  = i_is_pressed && !r_pressPrev;
    assign w_oneHot     = DATA_W'(1) << r_pos;

    always_ff @(posedge i_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_data      <= '0;
            r_mode      <= MODE_STATIC;
            r_bright    <= '0;
            r_pwm       <= '0;
            r_pressPrev <= 1'b0;
        end else begin
            if (i_data_valid) begin
                r_data <= i_data;
            end
            r_mode      <= mode_e'(i_mode);
            r_bright    <= i_brightness;
            r_pwm       <= r_pwm + 1'b1;
            r_pressPrev <= i_is_pressed;
        end
    end

    always_ff @(posedge i_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
            r_pos      <= '0;
        end else if (w_modeChange) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b1;
            r_pos      <= '0;
        end else if (w_blinkWrap) begin
            r_blinkCnt <= '0;
            r_phase    <= ~r_phase;
            r_pos      <= (r_pos == PW'(DATA_W - 1)) ? '0 : r_pos + 1'b1;
        end else if (w_tick) begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    // A fresh press reloads the stretch even if a tick lands on the same cycle.
    always_ff @(posedge i_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_stretch <= '0;
        end else if (w_pressRise) begin
            r_stretch <= SW'(STRETCH_TICKS);
        end else if (w_tick && (r_stretch != '0)) begin
            r_stretch <= r_stretch - 1'b1;
        end
    end

    always_comb begin
        w_pre = '0;
        case (r_mode)
            MODE_STATIC:  w_pre = r_data;
            MODE_BLINK:   w_pre = r_phase ? r_data : '0;
            MODE_MARQUEE: w_pre = w_oneHot;
            default:      w_pre = '0;
        endcase

        w_pwmOn = 1'b0;
        if (r_bright == '1) begin
            w_pwmOn = 1'b1;
        end else if (r_bright != '0) begin
            w_pwmOn = (r_pwm < r_bright);
        end

        w_dataLit  = w_pwmOn ? w_pre : '0;
        w_pressLit = i_is_pressed || (r_stretch != '0);
    end

    always_ff @(posedge i_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            o_led <= {(DATA_W + 1){OFF_LVL}};
        end else begin
            o_led <= {w_pressLit, w_dataLit} ^ {(DATA_W + 1){OFF_LVL}};
        end
    end

endmodule

// File: doc/led_indicator_ctrl.md
Name: led_indicator_ctrl

Overview:
Parametrised successor to the 4-LED hex/press indicator.
- Drives DATA_W data LEDs plus one key-press LED on the board's active-low LED bank.
- Adds latched data capture, display modes (static, blink, marquee, off), PWM brightness, and a pulse-stretched press indicator.
- Sits between the key/SPI-control logic and the LED pins.

Parameters:
- DATA_W, 4: number of data LEDs (1..16).
- PWM_BITS, 4: brightness resolution.
- TICK_DIV, 27000: clk cycles per timing tick (1 ms at 27 MHz). Minimum 2.
- BLINK_TICKS, 250: ticks per blink half-period and per marquee step (>=1).
- STRETCH_TICKS, 50: minimum press-indicator on-time in ticks (>=1).
- ACTIVE_LOW, 1: 1 means a lit LED drives 0; 0 means a lit LED drives 1.

Ports:
- clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- data  in  DATA_W  value to display.
- data_valid  in  1  capture strobe for data.
- is_pressed  in  1  debounced, clk-synchronous key level.
- mode  in  2  0=STATIC, 1=BLINK, 2=MARQUEE, 3=OFF.
- brightness  in  PWM_BITS  data-LED duty.
- led  out  DATA_W+1  [DATA_W-1:0] data LEDs, [DATA_W] press LED.

Behaviour:
- Clock and reset: single clock clk. Reset sys_rst_n is asynchronous and active-low.
- Reset values:
  - led = all LEDs off (all 1s when ACTIVE_LOW=1).
  - data_reg=0, tick prescaler=0, blink counter=0, phase=1, marquee pos=0, stretch=0, pwm_cnt=0.
  - Reset asserted mid-operation forces these values immediately; no tick or stretch state survives.
- Data capture: data_reg <= data on every edge where data_valid=1, otherwise it holds.
- Latency: led is registered. A data/mode/brightness change sampled at edge N appears on led at edge N+1. From data_valid to led this is 2 edges.
- Logical lit(i) maps to the pin as led[i] = lit(i) XOR ACTIVE_LOW. data bit 1 means lit, so ACTIVE_LOW=1 gives led = ~data.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle at wrap.
- Blink/marquee counter: counts ticks 0..BLINK_TICKS-1. On the tick that wraps it:
  - phase toggles;
  - marquee pos increments, wrapping DATA_W-1 -> 0.
- Mode change: on any edge where mode differs from the previous sampled mode, the blink counter is cleared, phase=1 and pos=0. The prescaler is not cleared.
- Data-LED logical value (before PWM), by mode:
  - STATIC: data_reg.
  - BLINK: data_reg when phase=1, otherwise 0.
  - MARQUEE: one-hot at pos; data_reg is ignored.
  - OFF: 0.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, +1 per clk.
  - brightness=0: data LEDs off.
  - brightness=all-ones: always on (100%).
  - Otherwise a data LED is lit when pwm_cnt < brightness and its pre-PWM value is 1.
- Press LED (not PWM-gated, active in all modes):
  - A rising edge of is_pressed loads stretch=STRETCH_TICKS.
  - stretch decrements on each tick while nonzero.
  - lit = is_pressed OR (stretch != 0).
  - A re-press while stretching reloads STRETCH_TICKS.
  - A load and a tick in the same cycle: the load wins.
- Simultaneous events: data_valid and a mode change in the same cycle both take effect.

Decomposition:
- Shared package led_pkg: mode encodings MODE_STATIC/BLINK/MARQUEE/OFF (2-bit) and a LED_OFF helper for the ACTIVE_LOW polarity.
- Sub-module tick_gen (params TICK_DIV; ports clk, sys_rst_n, tick). Reusable by the display/key blocks.
- Everything else stays in led_indicator_ctrl.

Test Plan:
All tests use DATA_W=4, PWM_BITS=2, TICK_DIV=4, BLINK_TICKS=2, STRETCH_TICKS=3, ACTIVE_LOW=1.
1. Reset then STATIC, brightness=3, data=4'h5 with data_valid for 1 cycle -> led[3:0]=4'b1010 exactly 2 edges after the strobe. led[4]=1. Holds after data changes without a strobe.
2. Reset mid-run (pos=2, stretch=2) -> led=5'b11111 asynchronously. After release the counters restart from 0.
3. BLINK, data=4'hF, brightness=3 -> led[3:0] is 0000 for 8 clk, then 1111 for 8 clk, repeating. Switching to STATIC mid-off-phase shows 0000 on the next edge.
4. MARQUEE, brightness=3 -> led[3:0] steps 1110, 1101, 1011, 0111, 1110 every 8 clk, wrapping. A data strobe has no effect.
5. STATIC data=4'hF:
   - brightness=1 -> led[3:0]=0000 for 1 of every 4 clk;
   - brightness=2 -> 2 of 4;
   - brightness=0 -> always 1111.
6. is_pressed high for 1 clk -> led[4]=0 from the next edge until 3 ticks elapse (9–12 clk), then 1. A second press at tick 2 reloads the stretch, extending it.
